ps2_rx_frame: RTL and testbench

PS2_RX_FRAME -- requirements
Module: ps2_rx_frame

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_sync.sv | 23 ++
 rtl/ps2_rx_frame.sv | 123 ++++++++++++
 tb/tb_ps2_rx_frame.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types: frame state encoding, frame length, default timeout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int FRAME_BITS      = 11;
    localparam int TIMEOUT_DEFAULT = 10000;

    // PS/2 uses odd parity: data ones plus the parity bit must be odd.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for PS/2 lines; resets to 1 so an idle line reads high.
// Latency: 2 clk cycles.
// Backpressure: none.
module ps2_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: start, 8 data LSB first, odd parity, stop.
// Latency: result pulse 1 clk after the fall_edge that samples the stop bit.
// Backpressure: none; rx_valid/err_* are single-cycle pulses with no handshake.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fall_edge,
    input  logic       ps2_d_mouse,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_timeout,
    output logic       busy
);

    localparam int DATA_BITS = FRAME_BITS - 3;
    localparam int TW        = (TIMEOUT_CYCLES >= 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = '1;

    logic                 d_sync;
    ps2_state_t           state;
    ps2_state_t           state_nxt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [TW-1:0]        tmo_cnt;
    logic                 frame_end;
    logic                 tmo_fire;

    ps2_sync u_sync_data (
        .clk (clk),
        .rst (rst),
        .d   (ps2_d_mouse),
        .q   (d_sync)
    );

    assign busy = (state != IDLE);

    // A fall_edge in the expiry cycle takes precedence over the timeout.
    always_comb begin
        state_nxt = state;
        frame_end = 1'b0;
        tmo_fire  = 1'b0;
        if (fall_edge) begin
            case (state)
                IDLE:    if (!d_sync) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'(DATA_BITS - 1)) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (busy && tmo_cnt == TMO_LAST) begin
            state_nxt = IDLE;
            tmo_fire  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            tmo_cnt     <= '0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= tmo_fire;

            if (fall_edge || !busy || tmo_fire) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            // Re-arm the bit counter in IDLE so a timed-out frame cannot skew the next one.
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (fall_edge && state == DATA) begin
                shreg   <= {d_sync, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (fall_edge && state == PARITY) begin
                par_bit <= d_sync;
            end

            if (frame_end) begin
                if (!d_sync) begin
                    err_frame <= 1'b1;
                end else if (!parity_ok(shreg, par_bit)) begin
                    err_parity <= 1'b1;
                end else begin
                    rx_valid <= 1'b1;
                    rx_data  <= shreg;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Bench for ps2_rx_frame: directed frame table, timeout/reset corner cases, random frames.
module tb_ps2_rx_frame;
    import ps2_pkg::*;

    localparam int T = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       fall_edge;
    logic       ps2_d_mouse;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       err_parity;
    logic       err_frame;
    logic       err_timeout;
    logic       busy;

    always #5 clk = ~clk;

    ps2_rx_frame #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .fall_edge   (fall_edge),
        .ps2_d_mouse (ps2_d_mouse),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .err_parity  (err_parity),
        .err_frame   (err_frame),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_valid;
        logic       exp_perr;
        logic       exp_ferr;
        logic [7:0] exp_data;
    } frame_vec_t;

    frame_vec_t tbl[9];

    int tests = 0;
    int fails = 0;
    int n_valid = 0, n_perr = 0, n_ferr = 0, n_tmo = 0, n_excl = 0;
    int exp_valid = 0, exp_perr = 0, exp_ferr = 0, exp_tmo = 0;
    logic [7:0] model_data;

    // Independent pulse census over the whole run.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid)    n_valid++;
            if (err_parity)  n_perr++;
            if (err_frame)   n_ferr++;
            if (err_timeout) n_tmo++;
            if (int'(rx_valid) + int'(err_parity) + int'(err_frame) + int'(err_timeout) > 1)
                n_excl++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // 0 = good, 1 = parity error, 2 = framing error (stop error wins).
    function automatic int model_outcome(input logic [7:0] d, input logic p, input logic s);
        if (!s) return 2;
        if ((($countones(d) + int'(p)) % 2) == 0) return 1;
        return 0;
    endfunction

    // Present bit b, let it settle g cycles, then pulse fall_edge for one cycle.
    task automatic fe_pulse(input logic b, input int g);
        ps2_d_mouse = b;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        fall_edge = 1'b1;
        @(posedge clk);
        #1;
        fall_edge = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int g,
                              input int long_idx, input int long_gap,
                              input logic ev, input logic ep, input logic ef,
                              input logic [7:0] ed);
        logic [FRAME_BITS-1:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < FRAME_BITS; i++)
            fe_pulse(bits[i], (i == long_idx) ? long_gap : g);
        check("rx_valid", rx_valid, ev);
        check("err_parity", err_parity, ep);
        check("err_frame", err_frame, ef);
        check("err_timeout", err_timeout, 0);
        check("rx_data", rx_data, ed);
        check("busy_after_frame", busy, 0);
        if (ev) exp_valid++;
        if (ep) exp_perr++;
        if (ef) exp_ferr++;
        @(posedge clk);
        #1;
        check("pulse_clear", {rx_valid, err_parity, err_frame, err_timeout}, 0);
        check("rx_data_hold", rx_data, ed);
        ps2_d_mouse = 1'b1;
    endtask

    initial begin
        int n;
        int oc;
        logic [7:0] d;
        logic p, s;
        logic [7:0] b55;

        tbl[0] = '{8'hFA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFA};
        tbl[1] = '{8'hAA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFA};
        tbl[2] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFA};
        tbl[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80};
        tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};
        tbl[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
        tbl[7] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
        tbl[8] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C};

        rst = 1'b1;
        fall_edge = 1'b0;
        ps2_d_mouse = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_pulses", {rx_valid, err_parity, err_frame, err_timeout}, 0);

        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].data, tbl[i].par, tbl[i].stop, 3, -1, 0,
                       tbl[i].exp_valid, tbl[i].exp_perr, tbl[i].exp_ferr, tbl[i].exp_data);
            model_data = tbl[i].exp_data;
        end

        // Line high at a fall_edge in IDLE is a glitch, not a start bit.
        fe_pulse(1'b1, 3);
        check("glitch_busy", busy, 0);
        check("glitch_pulses", {rx_valid, err_parity, err_frame, err_timeout}, 0);
        @(posedge clk);
        #1;
        check("glitch_busy_hold", busy, 0);

        // Partial frame (start + 4 bits), then silence: err_timeout T cycles after last edge.
        fe_pulse(1'b0, 3);
        for (int i = 0; i < 4; i++) fe_pulse(1'b1, 3);
        ps2_d_mouse = 1'b1;
        n = 0;
        while (n < 3 * T && !err_timeout) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("timeout_latency", n, T);
        check("timeout_busy", busy, 0);
        check("timeout_rx_data", rx_data, model_data);
        exp_tmo++;
        @(posedge clk);
        #1;
        check("timeout_pulse_clear", err_timeout, 0);
        model_data = 8'h00;
        send_frame(8'h00, 1'b1, 1'b1, 3, -1, 0, 1'b1, 1'b0, 1'b0, model_data);

        // A fall_edge landing exactly on the expiry cycle is accepted.
        model_data = 8'h3C;
        send_frame(8'h3C, 1'b1, 1'b1, 3, 5, T - 1, 1'b1, 1'b0, 1'b0, model_data);

        // Reset after 6 bits of a frame discards it silently.
        b55 = 8'h55;
        fe_pulse(1'b0, 3);
        for (int i = 0; i < 5; i++) fe_pulse(b55[i], 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_busy", busy, 0);
        check("midreset_pulses", {rx_valid, err_parity, err_frame, err_timeout}, 0);
        ps2_d_mouse = 1'b1;
        repeat (T + 5) @(posedge clk);
        #1;
        model_data = 8'h55;
        send_frame(8'h55, 1'b1, 1'b1, 3, -1, 0, 1'b1, 1'b0, 1'b0, model_data);

        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom_range(0, 255));
            p = ~^d;
            s = 1'b1;
            case ($urandom_range(0, 3))
                2: p = ~p;
                3: s = 1'b0;
                default: ;
            endcase
            oc = model_outcome(d, p, s);
            if (oc == 0) model_data = d;
            send_frame(d, p, s, $urandom_range(2, 6), -1, 0,
                       oc == 0, oc == 1, oc == 2, model_data);
        end

        repeat (4) @(posedge clk);
        #1;
        check("total_rx_valid", n_valid, exp_valid);
        check("total_err_parity", n_perr, exp_perr);
        check("total_err_frame", n_ferr, exp_ferr);
        check("total_err_timeout", n_tmo, exp_tmo);
        check("exclusive_pulses", n_excl, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
